// File: rtl/cache_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_write_ctrl
// Description : Fill controller for the 7-channel line cache. Accepts a
//               valid/ready pixel stream and writes each image row into one
//               cache channel (addresses 0..ROW_LENGTH-1). Channels are used
//               round-robin. A per-channel filled mask tells the read stage
//               which channels hold a complete row. The consumer frees a
//               channel with release_i. A row is never written into a channel
//               that is still marked filled.
//
// Ports:
//   clk                 : clock, all logic on posedge
//   rst_i               : asynchronous active-high reset
//   start_i, num_rows_i : begin a fill of num_rows_i rows (IDLE only)
//   pixel_valid_i/_data_i, pixel_ready_o : pixel stream handshake
//   release_i           : per-channel free pulses from the consumer
//   wr_en_o, channel_wr_sel_o, address_wr_o, cache_data_o : cache write port
//   filled_mask_o       : channel k holds a complete, unreleased row
//   row_done_o, row_done_channel_o : row completion pulse and its channel
//   fill_done_o         : fill completion pulse
//   busy_o              : controller is not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module cache_write_ctrl #(
    parameter int BIT_WIDTH               = 8,
    parameter int CACHE_CHANNELS          = 7,
    parameter int CACHE_CHANNEL_BIT_WIDTH = 3,
    parameter int CACHE_ADDRESS_BIT_WIDTH = 5,
    parameter int ROW_LENGTH              = 32
) (
    input  logic                               clk,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [7:0]                         num_rows_i,
    input  logic                               pixel_valid_i,
    input  logic [BIT_WIDTH-1:0]               pixel_data_i,
    output logic                               pixel_ready_o,
    input  logic [CACHE_CHANNELS-1:0]          release_i,
    output logic                               wr_en_o,
    output logic [CACHE_CHANNEL_BIT_WIDTH-1:0] channel_wr_sel_o,
    output logic [CACHE_ADDRESS_BIT_WIDTH-1:0] address_wr_o,
    output logic [BIT_WIDTH-1:0]               cache_data_o,
    output logic [CACHE_CHANNELS-1:0]          filled_mask_o,
    output logic                               row_done_o,
    output logic [CACHE_CHANNEL_BIT_WIDTH-1:0] row_done_channel_o,
    output logic                               fill_done_o,
    output logic                               busy_o
);

    localparam logic [CACHE_ADDRESS_BIT_WIDTH-1:0] c_LAST_ADDR =
        CACHE_ADDRESS_BIT_WIDTH'(ROW_LENGTH - 1);
    localparam logic [CACHE_CHANNEL_BIT_WIDTH-1:0] c_LAST_CHAN =
        CACHE_CHANNEL_BIT_WIDTH'(CACHE_CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SLOT = 2'd1,
        S_WRITE     = 2'd2,
        S_ROW_END   = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [CACHE_CHANNEL_BIT_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CACHE_ADDRESS_BIT_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                           row_cnt_q, row_cnt_d;
    logic [7:0]                           num_rows_q, num_rows_d;
    logic                                 wr_en_q, wr_en_d;
    logic [CACHE_CHANNEL_BIT_WIDTH-1:0]   wr_chan_q, wr_chan_d;
    logic [CACHE_ADDRESS_BIT_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [BIT_WIDTH-1:0]                 wr_data_q, wr_data_d;
    logic [CACHE_CHANNELS-1:0]            mask_q, mask_d;
    logic                                 row_done_q, row_done_d;
    logic [CACHE_CHANNEL_BIT_WIDTH-1:0]   row_done_chan_q, row_done_chan_d;
    logic                                 fill_done_q, fill_done_d;

    logic                                 w_handshake;
    logic [CACHE_CHANNELS-1:0]            w_ptr_onehot;
    logic [7:0]                           w_row_cnt_inc;
    logic [CACHE_CHANNEL_BIT_WIDTH-1:0]   w_ptr_next;

    // Ready is a pure function of state so the source never sees a
    // combinational path from its own valid back to ready.
    assign pixel_ready_o = (state_q == S_WRITE);
    assign busy_o        = (state_q != S_IDLE);
    assign w_handshake   = pixel_valid_i & pixel_ready_o;
    assign w_ptr_onehot  = CACHE_CHANNELS'(1) << ptr_q;
    assign w_row_cnt_inc = row_cnt_q + 8'd1;
    assign w_ptr_next    = (ptr_q == c_LAST_CHAN) ? '0
                                                  : ptr_q + CACHE_CHANNEL_BIT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        addr_d          = addr_q;
        row_cnt_d       = row_cnt_q;
        num_rows_d      = num_rows_q;
        wr_en_d         = 1'b0;
        wr_chan_d       = wr_chan_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        row_done_d      = 1'b0;
        row_done_chan_d = row_done_chan_q;
        fill_done_d     = 1'b0;
        // Releases apply in every state; a set in ROW_END is OR-ed in after
        // this so a same-edge set beats a release of the same channel.
        mask_d          = mask_q & ~release_i;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (num_rows_i != 8'd0) begin
                        num_rows_d = num_rows_i;
                        row_cnt_d  = 8'd0;
                        addr_d     = '0;
                        state_d    = S_WAIT_SLOT;
                    end else begin
                        // Empty fill: acknowledge immediately, never go busy.
                        fill_done_d = 1'b1;
                    end
                end
            end

            S_WAIT_SLOT: begin
                // Uses the registered mask, so a release is seen one cycle
                // after it is pulsed.
                if (!mask_q[ptr_q]) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                if (w_handshake) begin
                    wr_en_d   = 1'b1;
                    wr_chan_d = ptr_q;
                    wr_addr_d = addr_q;
                    wr_data_d = pixel_data_i;
                    if (addr_q == c_LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_ROW_END;
                    end else begin
                        addr_d = addr_q + CACHE_ADDRESS_BIT_WIDTH'(1);
                    end
                end
            end

            S_ROW_END: begin
                // The last pixel is on the cache port during this cycle, so
                // the mask is published only once the cache holds the row.
                mask_d          = mask_d | w_ptr_onehot;
                row_done_d      = 1'b1;
                row_done_chan_d = ptr_q;
                row_cnt_d       = w_row_cnt_inc;
                ptr_d           = w_ptr_next;
                if (w_row_cnt_inc == num_rows_q) begin
                    fill_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT_SLOT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            addr_q          <= '0;
            row_cnt_q       <= 8'd0;
            num_rows_q      <= 8'd0;
            wr_en_q         <= 1'b0;
            wr_chan_q       <= '0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            mask_q          <= '0;
            row_done_q      <= 1'b0;
            row_done_chan_q <= '0;
            fill_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            addr_q          <= addr_d;
            row_cnt_q       <= row_cnt_d;
            num_rows_q      <= num_rows_d;
            wr_en_q         <= wr_en_d;
            wr_chan_q       <= wr_chan_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            mask_q          <= mask_d;
            row_done_q      <= row_done_d;
            row_done_chan_q <= row_done_chan_d;
            fill_done_q     <= fill_done_d;
        end
    end

    assign wr_en_o            = wr_en_q;
    assign channel_wr_sel_o   = wr_chan_q;
    assign address_wr_o       = wr_addr_q;
    assign cache_data_o       = wr_data_q;
    assign filled_mask_o      = mask_q;
    assign row_done_o         = row_done_q;
    assign row_done_channel_o = row_done_chan_q;
    assign fill_done_o        = fill_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_write_ctrl
// Description : Self-checking bench for cache_write_ctrl. A transaction-level
//               model tracks the fill as "pixel n of the fill goes to channel
//               (first + n/ROW_LENGTH) mod 7 at address n mod ROW_LENGTH",
//               plus the filled mask as a set of completed rows minus
//               releases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_write_ctrl;

    localparam int RL = 32;
    localparam int NCH = 7;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] num_rows_i;
    logic       pixel_valid_i;
    logic [7:0] pixel_data_i;
    logic       pixel_ready_o;
    logic [6:0] release_i;
    logic       wr_en_o;
    logic [2:0] channel_wr_sel_o;
    logic [4:0] address_wr_o;
    logic [7:0] cache_data_o;
    logic [6:0] filled_mask_o;
    logic       row_done_o;
    logic [2:0] row_done_channel_o;
    logic       fill_done_o;
    logic       busy_o;

    cache_write_ctrl #(
        .BIT_WIDTH              (8),
        .CACHE_CHANNELS         (NCH),
        .CACHE_CHANNEL_BIT_WIDTH(3),
        .CACHE_ADDRESS_BIT_WIDTH(5),
        .ROW_LENGTH             (RL)
    ) u_dut (
        .clk               (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .num_rows_i        (num_rows_i),
        .pixel_valid_i     (pixel_valid_i),
        .pixel_data_i      (pixel_data_i),
        .pixel_ready_o     (pixel_ready_o),
        .release_i         (release_i),
        .wr_en_o           (wr_en_o),
        .channel_wr_sel_o  (channel_wr_sel_o),
        .address_wr_o      (address_wr_o),
        .cache_data_o      (cache_data_o),
        .filled_mask_o     (filled_mask_o),
        .row_done_o        (row_done_o),
        .row_done_channel_o(row_done_channel_o),
        .fill_done_o       (fill_done_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic       m_busy;
    int         m_ptr;
    logic [6:0] m_mask;
    int         m_pix;       // next address within the current row
    int         m_rows;
    int         m_nr;
    logic       m_rd_arm;    // last pixel of a row was accepted last cycle
    int         writes;
    int         last_wr_ch, last_wr_addr, last_rd_ch;
    int         se_hits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ptr = 0; m_mask = '0; m_pix = 0;
        m_rows = 0; m_nr = 0; m_rd_arm = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},  32'(wr_en_o), 0);
        check({tag, "_chan"},   32'(channel_wr_sel_o), 0);
        check({tag, "_addr"},   32'(address_wr_o), 0);
        check({tag, "_data"},   32'(cache_data_o), 0);
        check({tag, "_mask"},   32'(filled_mask_o), 0);
        check({tag, "_rd"},     32'(row_done_o), 0);
        check({tag, "_rd_ch"},  32'(row_done_channel_o), 0);
        check({tag, "_fd"},     32'(fill_done_o), 0);
        check({tag, "_busy"},   32'(busy_o), 0);
        check({tag, "_ready"},  32'(pixel_ready_o), 0);
    endtask

    // One clock cycle: drive inputs, advance the model, check every output.
    task automatic step(input logic v, input logic [7:0] d, input logic [6:0] rel,
                        input logic st, input logic [7:0] nr);
        logic       hs, rd_exp, fd_exp;
        int         ch_exp, ad_exp, rd_ch;
        logic [6:0] set_bits;
        pixel_valid_i = v; pixel_data_i = d; release_i = rel;
        start_i = st; num_rows_i = nr;
        #1;
        hs       = v && pixel_ready_o;
        ch_exp   = m_ptr;
        ad_exp   = m_pix;
        rd_exp   = m_rd_arm;
        m_rd_arm = 1'b0;
        rd_ch    = m_ptr;
        @(posedge clk);
        #1;
        set_bits = '0;
        fd_exp   = 1'b0;
        if (rd_exp) begin
            set_bits[m_ptr] = 1'b1;
            m_rows++;
            m_ptr = (m_ptr + 1) % NCH;
            if (m_rows == m_nr) begin
                fd_exp = 1'b1;
                m_busy = 1'b0;
            end
        end else if (!m_busy && st) begin
            if (nr == 8'd0) fd_exp = 1'b1;
            else begin
                m_busy = 1'b1; m_nr = int'(nr); m_rows = 0; m_pix = 0;
            end
        end
        m_mask = (m_mask & ~rel) | set_bits;
        if (hs) begin
            writes++;
            last_wr_ch   = int'(channel_wr_sel_o);
            last_wr_addr = int'(address_wr_o);
            if (m_pix == RL - 1) begin
                m_rd_arm = 1'b1;
                m_pix    = 0;
            end else begin
                m_pix++;
            end
        end
        check("wr_en", 32'(wr_en_o), 32'(hs));
        if (hs) begin
            check("wr_chan", 32'(channel_wr_sel_o), 32'(ch_exp));
            check("wr_addr", 32'(address_wr_o), 32'(ad_exp));
            check("wr_data", 32'(cache_data_o), 32'(d));
        end
        check("row_done", 32'(row_done_o), 32'(rd_exp));
        if (rd_exp) begin
            check("row_done_ch", 32'(row_done_channel_o), 32'(rd_ch));
            last_rd_ch = int'(row_done_channel_o);
        end
        check("fill_done", 32'(fill_done_o), 32'(fd_exp));
        check("mask", 32'(filled_mask_o), 32'(m_mask));
        check("busy", 32'(busy_o), 32'(m_busy));
        if (!m_busy || m_mask[m_ptr]) check("ready_blocked", 32'(pixel_ready_o), 0);
    endtask

    // Stream pixels until the fill ends (or the mask is full / max_wr writes).
    // mode 0: valid=1, data=address; 1: valid every other cycle;
    // 2: random valid and random releases; 3: release ch3 in its ROW_END;
    // 4: valid=1, random data.
    task automatic feed(input int mode, input int budget, input logic stop_full, input int max_wr);
        int         cyc;
        int         w0;
        logic       v;
        logic [7:0] d;
        logic [6:0] rel;
        logic       se;
        cyc = 0;
        w0  = writes;
        while (m_busy && !(stop_full && m_mask == 7'h7F) &&
               !(max_wr != 0 && writes - w0 >= max_wr) && cyc < budget) begin
            rel = '0; se = 1'b0; v = 1'b1; d = 8'($urandom);
            case (mode)
                0: d = 8'(m_pix);
                1: v = (cyc % 2) == 0;
                2: begin
                    v = ($urandom_range(3, 0) != 0);
                    if ($urandom_range(7, 0) == 0) rel = 7'($urandom);
                end
                3: if (m_rd_arm && m_ptr == 3) begin rel = 7'h08; se = 1'b1; end
                default: ;
            endcase
            step(v, d, rel, 1'b0, 8'd0);
            if (se) begin
                check("same_edge_mask3", 32'(filled_mask_o[3]), 1);
                se_hits++;
            end
            cyc++;
        end
        check("feed_budget", 32'(cyc < budget), 1);
    endtask

    initial begin
        int w0;
        writes = 0; se_hits = 0; last_wr_ch = -1; last_wr_addr = -1; last_rd_ch = -1;
        rst_i = 1'b1; start_i = 1'b0; num_rows_i = '0; pixel_valid_i = 1'b0;
        pixel_data_i = '0; release_i = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        rst_i = 1'b0;

        // Single row, data equal to address
        w0 = writes;
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd1);
        feed(0, 200, 1'b0, 0);
        step(1'b0, 8'd0, 7'd0, 1'b0, 8'd0);
        check("row1_writes", 32'(writes - w0), 32);
        check("row1_mask", 32'(filled_mask_o), 32'h01);
        check("row1_rd_ch", 32'(last_rd_ch), 0);

        // Reset mid-row after 10 pixels (row goes to channel 1)
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd1);
        feed(4, 200, 1'b0, 10);
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Wrap and backpressure, first row must land in channel 0 address 0
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd8);
        feed(4, 200, 1'b0, 1);
        check("postrst_ch", 32'(last_wr_ch), 0);
        check("postrst_addr", 32'(last_wr_addr), 0);
        feed(4, 2000, 1'b1, 0);
        check("wrap_full", 32'(filled_mask_o), 32'h7F);
        for (int i = 0; i < 20; i++) begin
            // start while busy must be ignored
            step(1'b1, 8'($urandom), 7'd0, (i == 5), 8'd3);
            check("wrap_hold_ready", 32'(pixel_ready_o), 0);
        end
        step(1'b1, 8'h55, 7'h01, 1'b0, 8'd0);
        check("rel_ready_n1", 32'(pixel_ready_o), 0);
        step(1'b1, 8'h66, 7'h00, 1'b0, 8'd0);
        check("rel_ready_n2", 32'(pixel_ready_o), 1);
        feed(4, 200, 1'b0, 0);
        check("wrap_row8_ch", 32'(last_rd_ch), 0);
        check("wrap_end_mask", 32'(filled_mask_o), 32'h7F);
        check("wrap_end_busy", 32'(busy_o), 0);

        // Bursty source
        step(1'b0, 8'd0, 7'h7F, 1'b0, 8'd0);
        w0 = writes;
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd1);
        feed(1, 400, 1'b0, 0);
        check("bursty_writes", 32'(writes - w0), 32);

        // Zero-row start
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd0);
        check("zero_fd", 32'(fill_done_o), 1);
        check("zero_busy", 32'(busy_o), 0);
        step(1'b0, 8'd0, 7'd0, 1'b0, 8'd0);
        check("zero_fd_pulse", 32'(fill_done_o), 0);

        // Same-edge release and set on channel 3
        step(1'b0, 8'd0, 7'h7F, 1'b0, 8'd0);
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd7);
        feed(3, 1000, 1'b0, 0);
        check("same_edge_seen", 32'(se_hits != 0), 1);

        // Randomised fill with random releases
        step(1'b0, 8'd0, 7'h7F, 1'b0, 8'd0);
        step(1'b0, 8'd0, 7'd0, 1'b1, 8'd10);
        feed(2, 6000, 1'b0, 0);
        step(1'b0, 8'd0, 7'd0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
